phase_sequencer: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath. It replaces the chain of delayed clocks with single-clock, one-hot phase enables: fetch, decode/register read, execute, data memory and write-back. It consumes the decode control outputs (mem_read, mem_write, reg_write, branch, uncondbranch) and the ALU zero flag, and skips phases an instruction does not need. It also handles the memory wait handshake, halt requests and retired-instruction counting.

---
 rtl/phase_sequencer_if.sv | 51 +++++
 rtl/phase_sequencer.sv | 179 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
// Control bundle between the LEGv8 multi-cycle sequencer and its datapath.
//   master : datapath/control side. Drives start, halt_req, decode controls,
//            zero, mem_ready. Receives phase strobes, PC control and status.
//   slave  : sequencer side (phase_sequencer).
// Parameter CNT_WIDTH sizes the retired-instruction counter.
// ---------------------------------------------------------------------------
interface phase_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    // requests and decode controls toward the sequencer
    logic                 start;
    logic                 halt_req;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 branch;
    logic                 uncondbranch;
    logic                 zero;
    logic                 mem_ready;

    // phase strobes, PC control and status from the sequencer
    logic                 fetch_en;
    logic                 decode_en;
    logic                 read_en;
    logic                 exec_en;
    logic                 mem_en;
    logic                 wb_en;
    logic                 pc_en;
    logic                 pc_src;
    logic [2:0]           phase;
    logic                 busy;
    logic                 halted;
    logic                 error;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        output start, halt_req, mem_read, mem_write, reg_write,
               branch, uncondbranch, zero, mem_ready,
        input  fetch_en, decode_en, read_en, exec_en, mem_en, wb_en,
               pc_en, pc_src, phase, busy, halted, error, retired
    );

    modport slave (
        input  start, halt_req, mem_read, mem_write, reg_write,
               branch, uncondbranch, zero, mem_ready,
        output fetch_en, decode_en, read_en, exec_en, mem_en, wb_en,
               pc_en, pc_src, phase, busy, halted, error, retired
    );
endinterface

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Single-clock multi-cycle control sequencer for the LEGv8 datapath. Walks
// IF -> ID -> EX -> [MEM] -> [WB], skipping phases an instruction does not
// need, waits on data memory with an optional timeout, honours halt requests
// at instruction boundaries and counts retired instructions.
// Ports:
//   i_clk    : system clock, rising edge
//   i_reset  : synchronous, active-high reset
//   io_bus   : phase_sequencer_if.slave (controls in; strobes/status out)
// Parameters:
//   CNT_WIDTH   : retired counter width
//   MEM_TIMEOUT : MEM wait cycles before an error halt (0 disables)
// ---------------------------------------------------------------------------
module phase_sequencer #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    phase_sequencer_if.slave  io_bus
);

    localparam int unsigned WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int unsigned WAIT_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam bit          TMO_ON    = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_reg_write;
    logic                  r_branch;
    logic                  r_uncond;
    logic                  r_zero;
    logic                  r_halt_pending;
    logic                  r_error;
    logic [WAIT_W-1:0]     r_wait;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_zero_eff;
    logic                  w_in_instr;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, completion and timeout decode
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        w_zero_eff = r_zero;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_next = S_IF;
                end
            end
            S_IF: w_next = S_ID;
            S_ID: w_next = S_EX;
            S_EX: begin
                // branches resolve here, so use the live flag
                w_zero_eff = io_bus.zero;
                if (r_mem_read || r_mem_write) begin
                    w_next = S_MEM;
                end else if (r_reg_write) begin
                    w_next = S_WB;
                end else begin
                    w_complete = 1'b1;
                end
            end
            S_MEM: begin
                if (io_bus.mem_ready) begin
                    if (r_reg_write) begin
                        w_next = S_WB;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else if (TMO_ON && (r_wait == WAIT_W'(WAIT_LAST))) begin
                    // this is the last allowed wait cycle
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_WB: w_complete = 1'b1;
            S_HALT: begin
                if (io_bus.start && !r_error) begin
                    w_next = S_IF;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_complete) begin
            w_next = (r_halt_pending || io_bus.halt_req) ? S_HALT : S_IF;
        end
    end

    assign w_in_instr = (r_state == S_IF) || (r_state == S_ID) || (r_state == S_EX) ||
                        (r_state == S_MEM) || (r_state == S_WB);

    // Latched controls, halt/error flags, MEM wait counter, retired counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_reg_write    <= 1'b0;
            r_branch       <= 1'b0;
            r_uncond       <= 1'b0;
            r_zero         <= 1'b0;
            r_halt_pending <= 1'b0;
            r_error        <= 1'b0;
            r_wait         <= '0;
            r_retired      <= '0;
        end else begin
            if (r_state == S_ID) begin
                r_mem_read  <= io_bus.mem_read;
                r_mem_write <= io_bus.mem_write;
                r_reg_write <= io_bus.reg_write;
                r_branch    <= io_bus.branch;
                r_uncond    <= io_bus.uncondbranch;
            end
            if (r_state == S_EX) begin
                r_zero <= io_bus.zero;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            // counts only cycles that stay in MEM; any exit clears it
            if ((r_state == S_MEM) && (w_next == S_MEM)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_next == S_HALT) begin
                r_halt_pending <= 1'b0;
            end else if (w_in_instr && io_bus.halt_req) begin
                r_halt_pending <= 1'b1;
            end
            if (w_complete) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
        end
    end

    // Moore phase strobes and status
    assign io_bus.fetch_en  = (r_state == S_IF);
    assign io_bus.decode_en = (r_state == S_ID);
    assign io_bus.read_en   = (r_state == S_ID);
    assign io_bus.exec_en   = (r_state == S_EX);
    assign io_bus.mem_en    = (r_state == S_MEM);
    assign io_bus.wb_en     = (r_state == S_WB);
    assign io_bus.phase     = r_state;
    assign io_bus.busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign io_bus.halted    = (r_state == S_HALT);
    assign io_bus.error     = r_error;
    assign io_bus.retired   = r_retired;

    // PC update in the completion cycle; pc_src forced low otherwise
    assign io_bus.pc_en  = w_complete;
    assign io_bus.pc_src = w_complete && (r_uncond || (r_branch && w_zero_eff));

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
// Directed bench for phase_sequencer (CNT_WIDTH=4, MEM_TIMEOUT=15). Each
// instruction pushes its expected completion (pc_src, latency, halt) to a
// scoreboard queue; the entry is popped when pc_en is seen.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

    localparam int unsigned CW  = 4;
    localparam int unsigned TMO = 15;

    typedef struct {
        string name;
        bit    pc_src;
        int    cycles;
        bit    halt_after;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [CW-1:0] exp_ret;

    always #5 clk = ~clk;

    phase_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    phase_sequencer #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // all outputs except retired, packed for zero checks
    function automatic logic [13:0] outs();
        return {bus.fetch_en, bus.decode_en, bus.read_en, bus.exec_en, bus.mem_en,
                bus.wb_en, bus.pc_en, bus.pc_src, bus.busy, bus.halted, bus.error,
                bus.phase};
    endfunction

    function automatic logic [5:0] strobes_for(input int ph);
        case (ph)
            1:       return 6'b100000;
            2:       return 6'b011000;
            3:       return 6'b000100;
            4:       return 6'b000010;
            5:       return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] strobes();
        return {bus.fetch_en, bus.decode_en, bus.read_en, bus.exec_en, bus.mem_en, bus.wb_en};
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.halt_req = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0;
        bus.branch = 1'b0; bus.uncondbranch = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    endtask

    // decode controls only valid in ID; elsewhere drive the complement
    task automatic drive_phase(input int ph, input bit mr, mw, rw, br, ub, z);
        bus.mem_read     = (ph == 2) ? mr : ~mr;
        bus.mem_write    = (ph == 2) ? mw : ~mw;
        bus.reg_write    = (ph == 2) ? rw : ~rw;
        bus.branch       = (ph == 2) ? br : ~br;
        bus.uncondbranch = (ph == 2) ? ub : ~ub;
        bus.zero         = (ph == 3) ? z  : ~z;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_retired", 32'(bus.retired), 32'd0);
        reset   = 1'b0;
        exp_ret = '0;
    endtask

    task automatic start_from_rest();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("start_phase", 32'(bus.phase), 32'd1);
    endtask

    // Entered away from an edge with the DUT in IF; leaves it at the next instruction boundary
    task automatic run_instr(input string name, input bit mr, mw, rw, br, ub, z,
                             input int wait_cycles, input bit hreq);
        exp_t e;
        exp_t got;
        int   cyc;
        int   ph_exp;
        int   mem_cnt;
        bit   done;
        e.name       = name;
        e.pc_src     = ub | (br & z);
        e.cycles     = 3 + ((mr | mw) ? 1 + wait_cycles : 0) + (rw ? 1 : 0);
        e.halt_after = hreq;
        sb.push_back(e);
        cyc = 0; mem_cnt = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            cyc++;
            if (cyc <= 3)                                       ph_exp = cyc;
            else if ((mr | mw) && (cyc <= 4 + wait_cycles))     ph_exp = 4;
            else                                                ph_exp = 5;
            drive_phase(ph_exp, mr, mw, rw, br, ub, z);
            bus.halt_req  = hreq && (ph_exp == 2);
            bus.mem_ready = (ph_exp == 4) && (mem_cnt == wait_cycles);
            if (ph_exp == 4) mem_cnt++;
            #1;
            check({name, "_phase"}, 32'(bus.phase), 32'(ph_exp));
            check({name, "_strobes"}, 32'(strobes()), 32'(strobes_for(ph_exp)));
            if (bus.pc_en === 1'b1) begin
                done = 1'b1;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check({got.name, "_pc_src"}, 32'(bus.pc_src), 32'(got.pc_src));
                    check({got.name, "_latency"}, 32'(cyc), 32'(got.cycles));
                end
            end
            @(negedge clk);
        end
        if (!done) check({name, "_pc_en_timeout"}, 32'd0, 32'd1);
        idle_inputs();
        exp_ret = exp_ret + CW'(1);
        #1;
        check({name, "_retired"}, 32'(bus.retired), 32'(exp_ret));
        check({name, "_next_phase"}, 32'(bus.phase), e.halt_after ? 32'd6 : 32'd1);
    endtask

    initial begin
        int mem_cycles;
        exp_ret = '0;
        reset   = 1'b1;
        idle_inputs();

        // reset state and basic instruction mix
        do_reset();
        start_from_rest();
        run_instr("add",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_instr("ldur",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        run_instr("cbz_t", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        run_instr("cbz_n", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_instr("b",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_instr("stur",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        run_instr("ldur0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // halt request during ID, then resume
        run_instr("add_h", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_busy", 32'(bus.busy), 32'd0);
        start_from_rest();
        check("resume_error", 32'(bus.error), 32'd0);
        run_instr("orr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // STUR with memory never ready -> timeout halt
        for (int c = 1; c <= 3; c++) begin
            drive_phase(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check("tmo_pre_phase", 32'(bus.phase), 32'(c));
            @(negedge clk);
        end
        idle_inputs();
        mem_cycles = 0;
        #1;
        while ((bus.phase === 3'd4) && (mem_cycles < 40)) begin
            mem_cycles++;
            if (bus.pc_en !== 1'b0) check("tmo_pc_en", 32'(bus.pc_en), 32'd0);
            @(negedge clk);
            #1;
        end
        check("tmo_mem_cycles", 32'(mem_cycles), 32'(TMO));
        check("tmo_phase", 32'(bus.phase), 32'd6);
        check("tmo_error", 32'(bus.error), 32'd1);
        check("tmo_halted", 32'(bus.halted), 32'd1);
        check("tmo_retired", 32'(bus.retired), 32'(exp_ret));
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("tmo_start_ignored", 32'(bus.phase), 32'd6);
        check("tmo_error_sticky", 32'(bus.error), 32'd1);

        // start + halt_req together in IDLE: halt ignored
        do_reset();
        bus.halt_req = 1'b1;
        start_from_rest();
        bus.halt_req = 1'b0;
        run_instr("add_i", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // reset while in MEM
        for (int c = 1; c <= 4; c++) begin
            drive_phase(c, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            bus.mem_ready = 1'b0;
            if (c < 4) @(negedge clk);
        end
        #1;
        check("rst_mem_phase_before", 32'(bus.phase), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_mem_outs", 32'(outs()), 32'd0);
        check("rst_mem_retired", 32'(bus.retired), 32'd0);
        exp_ret = '0;

        // 16 retirements wrap a 4-bit counter
        start_from_rest();
        for (int n = 0; n < 16; n++) begin
            run_instr("wrap_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        end
        check("wrap_retired_zero", 32'(bus.retired), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
